// File: rtl/btn_conditioner.sv
// Button conditioner: per-button 2-flop synchronizer plus 4-state debounce FSM,
// producing a one-cycle press pulse and a debounced level for east and west.
// Optional auto-repeat while held is enabled by defining BTN_AUTOREPEAT_EN.

module btn_conditioner_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned REP_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_pulse,
  output logic o_level
);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_PRESS_CHK   = 2'd1,
    S_PRESSED     = 2'd2,
    S_RELEASE_CHK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_pulse;
  logic             w_pulse_nxt;
  logic             r_level;
  logic             w_level_nxt;

`ifdef BTN_AUTOREPEAT_EN
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] r_rep;
  logic [REP_W-1:0] w_rep_nxt;
  logic             r_rep_run;
  logic             w_rep_run_nxt;
  logic             w_rep_fire;
`else
  // Repeat parameters are accepted but have no function in this build.
  logic w_unused_rep;
  assign w_unused_rep = ^{REP_W'(REPEAT_DELAY), REP_W'(REPEAT_PERIOD)};
`endif

  // Two-flop synchronizer for the asynchronous pad input.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_level   <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      r_rep     <= '0;
      r_rep_run <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pulse   <= w_pulse_nxt;
      r_level   <= w_level_nxt;
`ifdef BTN_AUTOREPEAT_EN
      r_rep     <= w_rep_nxt;
      r_rep_run <= w_rep_run_nxt;
`endif
    end
  end

  // Next-state, counter and pulse decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_pulse_nxt   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    w_rep_nxt     = r_rep;
    w_rep_run_nxt = r_rep_run;
    // First repeat waits the long delay, later ones the shorter period.
    w_rep_fire    = r_rep_run ? (r_rep == REP_PERIOD_LAST)
                              : (r_rep == REP_DELAY_LAST);
`endif

    case (r_state)
      S_IDLE: begin
        if (r_sync2) begin
          w_state_nxt = S_PRESS_CHK;
          w_cnt_nxt   = '0;
        end
      end

      S_PRESS_CHK: begin
        if (!r_sync2) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt   = S_PRESSED;
          w_pulse_nxt   = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          w_rep_nxt     = '0;
          w_rep_run_nxt = 1'b0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      S_PRESSED: begin
        if (!r_sync2) begin
          // Repeat counter is left frozen while the release is qualified.
          w_state_nxt = S_RELEASE_CHK;
          w_cnt_nxt   = '0;
        end else begin
`ifdef BTN_AUTOREPEAT_EN
          if (w_rep_fire) begin
            w_pulse_nxt   = 1'b1;
            w_rep_nxt     = '0;
            w_rep_run_nxt = 1'b1;
          end else begin
            w_rep_nxt = r_rep + REP_W'(1);
          end
`endif
        end
      end

      S_RELEASE_CHK: begin
        if (r_sync2) begin
          // Bounce back to held: no new pulse, repeat delay restarts.
          w_state_nxt   = S_PRESSED;
          w_cnt_nxt     = '0;
`ifdef BTN_AUTOREPEAT_EN
          w_rep_nxt     = '0;
          w_rep_run_nxt = 1'b0;
`endif
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_level_nxt = (w_state_nxt == S_PRESSED) || (w_state_nxt == S_RELEASE_CHK);
  end

  assign o_pulse = r_pulse;
  assign o_level = r_level;

endmodule

module btn_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter int unsigned REP_W           = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_east_raw,
  input  logic btn_west_raw,
  output logic east_pulse,
  output logic west_pulse,
  output logic east_level,
  output logic west_level
);

  btn_conditioner_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REP_W           (REP_W)
  ) u_east (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (btn_east_raw),
    .o_pulse (east_pulse),
    .o_level (east_level)
  );

  btn_conditioner_ch #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD),
    .REP_W           (REP_W)
  ) u_west (
    .clk     (clk),
    .reset   (reset),
    .i_raw   (btn_west_raw),
    .o_pulse (west_pulse),
    .o_level (west_level)
  );

endmodule
